program_sequencer: RTL and testbench

Program sequencer sitting directly upstream of the control ROM: it generates the 3-bit ROM address stream and registers the returned 4-bit control word into the datapath control outputs `alu_sel`, `mux_sel` and `load`. A run is launched by `start` and steps through addresses 0 to `LAST_ADDR` either free-running or one word per `step` pulse. It then signals `done` and returns to idle. `abort` cancels a run cleanly at any time.

---
 rtl/program_sequencer.sv | 102 ++++++++++
 tb/tb_program_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// Program sequencer: walks the control ROM from address 0 to LAST_ADDR and
// registers each returned word onto the datapath control outputs.
module program_sequencer #(
    parameter int ADDR_W    = 3,
    parameter int CTRL_W    = 4,
    parameter int LAST_ADDR = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step_mode,
    input  logic              step,
    input  logic              abort,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [CTRL_W-1:0] rom_data,
    output logic [1:0]        alu_sel,
    output logic              mux_sel,
    output logic              load,
    output logic              busy,
    output logic              done,
    output logic [3:0]        issue_count
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic              mode_q, mode_n;
    logic [CTRL_W-1:0] ctrl_q, ctrl_n;
    logic [3:0]        cnt_q, cnt_n;
    logic              issue;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            pc     <= '0;
            mode_q <= 1'b0;
            ctrl_q <= '0;
            cnt_q  <= '0;
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            mode_q <= mode_n;
            ctrl_q <= ctrl_n;
            cnt_q  <= cnt_n;
        end
    end

    // Control word defaults to zero every edge so a word is only ever
    // presented for the single cycle after it was issued.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        mode_n  = mode_q;
        ctrl_n  = '0;
        cnt_n   = cnt_q;
        issue   = (state == RUN) && (!mode_q || step);
        if (abort) begin
            state_n = IDLE;
            pc_n    = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_n = RUN;
                        pc_n    = '0;
                        mode_n  = step_mode;
                        cnt_n   = '0;
                    end
                end
                RUN: begin
                    if (issue) begin
                        ctrl_n = rom_data;
                        cnt_n  = sat_inc(cnt_q);
                        if (pc == ADDR_W'(LAST_ADDR))
                            state_n = DONE;
                        else
                            pc_n = pc + ADDR_W'(1);
                    end
                end
                DONE: begin
                    state_n = IDLE;
                    pc_n    = '0;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign rom_addr    = pc;
    assign alu_sel     = ctrl_q[3:2];
    assign mux_sel     = ctrl_q[1];
    assign load        = ctrl_q[0];
    assign busy        = (state == RUN) || (state == DONE);
    assign done        = (state == DONE);
    assign issue_count = cnt_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: expected per-cycle outputs are queued
// as stimulus is planned and checked one entry per clock edge.
module tb_program_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, step_mode, step, abort;
    logic [2:0] rom_addr;
    logic [3:0] rom_data;
    logic [1:0] alu_sel;
    logic       mux_sel, load, busy, done;
    logic [3:0] issue_count;

    logic [3:0] rom [0:7];

    typedef struct {
        logic [3:0] c;
        logic       d;
        logic       b;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    program_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .step_mode  (step_mode),
        .step       (step),
        .abort      (abort),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .alu_sel    (alu_sel),
        .mux_sel    (mux_sel),
        .load       (load),
        .busy       (busy),
        .done       (done),
        .issue_count(issue_count)
    );

    always #5 clk = ~clk;
    assign rom_data = rom[rom_addr];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] c, input logic d, input logic b);
        exp_t e;
        e.c = c;
        e.d = d;
        e.b = b;
        sbq.push_back(e);
    endtask

    task automatic tick_check(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk({tag, "_sb_empty"}, 8'd1, 8'd0);
        end else begin
            e = sbq.pop_front();
            chk({tag, "_ctrl"}, {4'b0, alu_sel, mux_sel, load}, {4'b0, e.c});
            chk({tag, "_done"}, {7'b0, done}, {7'b0, e.d});
            chk({tag, "_busy"}, {7'b0, busy}, {7'b0, e.b});
        end
    endtask

    // Runs cycles until the scoreboard drains; start/abort are pulsed at the
    // given cycle indices (-1 disables).
    task automatic drain(input string tag, input int s1, input int s2, input int a);
        int i;
        i = 0;
        while (sbq.size() > 0 && i < 40) begin
            start = (i == s1) || (i == s2);
            abort = (i == a);
            tick_check(tag);
            i++;
        end
        start = 1'b0;
        abort = 1'b0;
        chk({tag, "_drain_timeout"}, 8'(sbq.size()), 8'd0);
    endtask

    task automatic push_free_run();
        push(4'b0000, 1'b0, 1'b1);
        for (int k = 0; k < 7; k++) push(rom[k], (k == 6), 1'b1);
        push(4'b0000, 1'b0, 1'b0);
    endtask

    initial begin
        rom[0] = 4'b0001; rom[1] = 4'b0101; rom[2] = 4'b1001; rom[3] = 4'b1101;
        rom[4] = 4'b1111; rom[5] = 4'b1111; rom[6] = 4'b1111; rom[7] = 4'b0000;
        start = 1'b0; step_mode = 1'b0; step = 1'b0; abort = 1'b0;

        // asynchronous reset before any clock edge
        rst = 1'b1;
        #1;
        chk("rst_ctrl", {4'b0, alu_sel, mux_sel, load}, 8'h00);
        chk("rst_busy_done", {6'b0, busy, done}, 8'h00);
        chk("rst_addr", {5'b0, rom_addr}, 8'h00);
        chk("rst_cnt", {4'b0, issue_count}, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // free-run
        push_free_run();
        drain("free", 0, -1, -1);
        chk("free_cnt", {4'b0, issue_count}, 8'd7);

        // step mode; step_mode toggled mid-run must be ignored
        step_mode = 1'b1;
        start = 1'b1;
        push(4'b0000, 1'b0, 1'b1);
        tick_check("step_launch");
        start = 1'b0;
        step_mode = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step = 1'b1;
            push(rom[k], (k == 6), 1'b1);
            tick_check("step_word");
            step = 1'b0;
            if (k < 6) begin
                push(4'b0000, 1'b0, 1'b1);
                push(4'b0000, 1'b0, 1'b1);
                tick_check("step_gap");
                tick_check("step_gap");
            end
        end
        push(4'b0000, 1'b0, 1'b0);
        tick_check("step_end");
        chk("step_cnt", {4'b0, issue_count}, 8'd7);

        // abort sampled while the address-3 word is on the outputs
        push(4'b0000, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) push(rom[k], 1'b0, 1'b1);
        push(4'b0000, 1'b0, 1'b0);
        push(4'b0000, 1'b0, 1'b0);
        drain("abort", 0, -1, 5);
        chk("abort_cnt", {4'b0, issue_count}, 8'd4);

        // start re-pulsed during RUN
        push_free_run();
        drain("restart", 0, 3, -1);
        chk("restart_cnt", {4'b0, issue_count}, 8'd7);

        // start with abort in IDLE stays idle and keeps the count
        push(4'b0000, 1'b0, 1'b0);
        push(4'b0000, 1'b0, 1'b0);
        drain("start_abort", 0, -1, 0);
        chk("start_abort_cnt", {4'b0, issue_count}, 8'd7);

        // reset mid-run at address 2, then a full replay
        push(4'b0000, 1'b0, 1'b1);
        push(rom[0], 1'b0, 1'b1);
        push(rom[1], 1'b0, 1'b1);
        drain("pre_rst", 0, -1, -1);
        chk("pre_rst_addr", {5'b0, rom_addr}, 8'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_ctrl", {4'b0, alu_sel, mux_sel, load}, 8'h00);
        chk("mid_rst_busy_done", {6'b0, busy, done}, 8'h00);
        chk("mid_rst_addr", {5'b0, rom_addr}, 8'h00);
        chk("mid_rst_cnt", {4'b0, issue_count}, 8'h00);
        rst = 1'b0;
        push_free_run();
        drain("replay", 0, -1, -1);
        chk("replay_cnt", {4'b0, issue_count}, 8'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
